fifo_dot_engine: RTL and testbench

- Downstream consumer of the NPU input FIFO: drains exactly VEC_LEN signed activations and multiplies each by a locally stored signed weight.
- Accumulates the dot product and presents it on a valid/ready output.
- Drives the FIFO read strobe directly. Data returns on the FIFO's registered output one cycle after the strobe.
- FIFO enable is tied high at the top level.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/dot_mac.sv | 39 +++
 rtl/fifo_dot_engine.sv | 116 +++++++++++
 tb/tb_fifo_dot_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and sizing helpers for the NPU dot-product engine.
// Holds the engine FSM encoding and default vector geometry.
package npu_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int VEC_LEN_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Wide enough for VEC_LEN full-scale signed products without overflow.
  function automatic int acc_width(input int dw, input int vl);
    return 2 * dw + $clog2(vl);
  endfunction

endpackage

// File: rtl/dot_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// sum is the combinational next value, exposed for the final capture.
module dot_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  sum
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        a_x;
  logic [PW-1:0]        b_x;
  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] acc;

  // Operands pre-extended so the truncated product is the exact signed one.
  assign a_x  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_x  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign prod = a_x * b_x;
  assign sum  = acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fifo_dot_engine.sv
// Drains VEC_LEN activations from the input FIFO into a weighted dot product.
// Define FIFO_DOT_ENGINE_RELU_EN to clamp negative results to zero.
module fifo_dot_engine
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int IDX_WIDTH  = $clog2(VEC_LEN),
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, VEC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  weight_we,
  input  logic [IDX_WIDTH-1:0]  weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_data,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int CW = IDX_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t                state;
  logic [CW-1:0]         issue_cnt;
  logic [IDX_WIDTH-1:0]  pend_idx;
  logic                  pending;
  logic [DATA_WIDTH-1:0] weight [VEC_LEN];
  logic [ACC_WIDTH-1:0]  sum;
  logic [ACC_WIDTH-1:0]  result_d;
  logic                  idle;
  logic                  w_ok;

  assign idle         = (state == IDLE);
  assign busy         = !idle;
  assign result_valid = (state == OUT);
  assign w_ok         = ({1'b0, weight_addr} < LAST);
  assign fifo_rd_en   = (state == FETCH) && !fifo_empty
                        && (issue_cnt < LAST);

`ifdef FIFO_DOT_ENGINE_RELU_EN
  assign result_d = sum[ACC_WIDTH-1] ? '0 : sum;
`else
  assign result_d = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        weight[i] <= '0;
      end
    end else if (idle && weight_we && w_ok) begin
      weight[weight_addr] <= weight_data;
    end
  end

  dot_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (idle && start),
    .en  (pending),
    .a   (fifo_data),
    .b   (weight[pend_idx]),
    .sum (sum)
  );

  // pending tracks the one-cycle FIFO read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      pend_idx  <= '0;
      pending   <= 1'b0;
      result    <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (fifo_rd_en) begin
        issue_cnt <= issue_cnt + ONE;
        pend_idx  <= issue_cnt[IDX_WIDTH-1:0];
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            issue_cnt <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (fifo_rd_en && issue_cnt == LAST - ONE) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          result <= result_d;
          state  <= OUT;
        end
        OUT: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dot_engine.sv
// Directed bench for fifo_dot_engine: FIFO model, dot-product scoreboard,
// per-cycle checks plus hand-computed literal results.
module tb_fifo_dot_engine;
  import npu_pkg::*;

  localparam int DW   = 8;
  localparam int VL   = 4;
  localparam int VL16 = 16;
  localparam int AW   = acc_width(DW, VL);
  localparam int AW16 = acc_width(DW, VL16);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, weight_we, result_ready;
  logic [1:0]    weight_addr;
  logic [DW-1:0] weight_data;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en, busy, result_valid;
  logic [AW-1:0] result;

  logic            start16, we16;
  logic [3:0]      addr16;
  logic [DW-1:0]   wdata16;
  logic            empty16, ready16;
  logic [DW-1:0]   data16;
  logic            rd16, busy16, valid16;
  logic [AW16-1:0] result16;

  assign empty16 = 1'b0;
  assign ready16 = 1'b1;
  assign data16  = 8'd127;

  fifo_dot_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .weight_we    (weight_we),
    .weight_addr  (weight_addr),
    .weight_data  (weight_data),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  fifo_dot_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .start        (start16),
    .weight_we    (we16),
    .weight_addr  (addr16),
    .weight_data  (wdata16),
    .fifo_empty   (empty16),
    .fifo_data    (data16),
    .fifo_rd_en   (rd16),
    .busy         (busy16),
    .result       (result16),
    .result_valid (valid16),
    .result_ready (ready16)
  );

  logic [DW-1:0] mem [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic flush;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int     errors = 0;
  int     checks = 0;
  longint exp_q[$];
  int     w_m[VL];
  bit     model_busy = 1'b0;
  int     run_base;

  logic          s_rd, s_valid, s_busy;
  logic [AW-1:0] s_result;
  logic          s16_rd, s16_valid, s16_busy;
  logic [AW16-1:0] s16_result;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dot4(input int base);
    longint s = 0;
    for (int i = 0; i < VL; i++) begin
      s += longint'(w_m[i]) * longint'($signed(mem[base+i]));
    end
    return s;
  endfunction

  // Per-cycle compare against the scoreboard and the busy model.
  task automatic step();
    @(negedge clk);
    s_rd = fifo_rd_en;  s_valid = result_valid;
    s_busy = busy;      s_result = result;
    s16_rd = rd16;      s16_valid = valid16;
    s16_busy = busy16;  s16_result = result16;
    if (rst) model_busy = 1'b0;
    chk("busy_model", s_busy, model_busy);
    if (fifo_empty) chk("rd_while_empty", s_rd, 0);
    if (s_valid) begin
      if (exp_q.size() == 0) begin
        chk("valid_without_run", s_valid, 0);
      end else begin
        chk("result_model", $signed(s_result), exp_q[0]);
        if (result_ready) void'(exp_q.pop_front());
      end
    end
    if (rst) begin
      chk("rst_valid", s_valid, 0);
      chk("rst_result", s_result, 0);
      chk("rst_rd", s_rd, 0);
    end else if (!model_busy && start) begin
      model_busy = 1'b1;
    end else if (s_valid && result_ready) begin
      model_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d[4], input int nvis, input bit expect_run);
    run_base = wr_ptr;
    for (int i = 0; i < 4; i++) mem[run_base+i] = d[i][7:0];
    if (expect_run) exp_q.push_back(dot4(run_base));
    wr_ptr = run_base + nvis;
  endtask

  task automatic wr_w(input int a, input int d);
    weight_we = 1'b1;
    weight_addr = a[1:0];
    weight_data = d[7:0];
    w_m[a] = d;
    step();
    weight_we = 1'b0;
  endtask

  initial begin
    longint exp16;
    int     rd_cnt;
    rst = 1'b1; flush = 1'b0;
    start = 0; weight_we = 0; weight_addr = 0; weight_data = 0;
    result_ready = 1'b1;
    start16 = 0; we16 = 0; addr16 = 0; wdata16 = 0;
    for (int i = 0; i < VL; i++) w_m[i] = 0;
    step();
    step();
    chk("reset_result", s_result, 0);
    chk("reset_busy16", s16_busy, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) wr_w(i, i + 1);
    load('{1, 1, 1, 1}, 4, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t1_rd", s_rd, (k <= 4));
      chk("t1_valid", s_valid, (k == 6));
      if (k == 6) chk("t1_result", $signed(s_result), 10);
    end

    load('{1, 2, 3, 4}, 2, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 6) wr_ptr = run_base + 4;
      step();
      chk("stall_rd", s_rd, (k == 1 || k == 2 || k == 6 || k == 7));
      chk("stall_valid", s_valid, (k == 9));
      if (k == 9) chk("stall_result", $signed(s_result), 30);
    end

    load('{2, 0, -1, 5}, 4, 1'b1);
    result_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 7);
      weight_we = (k == 8);
      weight_addr = 2'd0;
      weight_data = 8'd99;
      if (k == 11) result_ready = 1'b1;
      step();
      if (k >= 6 && k <= 11) begin
        chk("bp_valid", s_valid, 1);
        chk("bp_result", $signed(s_result), 19);
      end
      if (k == 12) begin
        chk("bp_idle_busy", s_busy, 0);
        chk("bp_idle_valid", s_valid, 0);
      end
    end
    start = 1'b0; weight_we = 1'b0;

    load('{1, 0, 0, 0}, 4, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) chk("busy_write_ignored", $signed(s_result), 1);
    end

    load('{3, 3, 3, 3}, 4, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk("abort_busy", s_busy, 0);
    chk("abort_rd", s_rd, 0);
    step();
    rst = 1'b0; flush = 1'b0;
    for (int i = 0; i < VL; i++) w_m[i] = 0;
    step();

    wr_w(0, 5);
    wr_w(1, -6);
    weight_we = 1'b1; weight_addr = 2'd3; weight_data = 8'd10;
    w_m[3] = 10;
    load('{1, 2, 3, 4}, 4, 1'b1);
    start = 1'b1; step(); start = 1'b0; weight_we = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("post_rst_valid", s_valid, (k == 6));
      if (k == 6) chk("post_rst_result", $signed(s_result), 33);
    end

    for (int i = 0; i < VL16; i++) begin
      we16 = 1'b1; addr16 = i[3:0]; wdata16 = 8'h80;
      step();
    end
    we16 = 1'b0;
    exp16 = 0;
    for (int i = 0; i < VL16; i++) exp16 += longint'(-128) * 127;
`ifdef FIFO_DOT_ENGINE_RELU_EN
    if (exp16 < 0) exp16 = 0;
`endif
    start16 = 1'b1; step(); start16 = 1'b0;
    rd_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (s16_rd) rd_cnt++;
      chk("s16_valid", s16_valid, (k == 18));
      if (k == 18) begin
        chk("s16_result_model", $signed(s16_result), exp16);
`ifdef FIFO_DOT_ENGINE_RELU_EN
        chk("s16_result", $signed(s16_result), 0);
`else
        chk("s16_result", $signed(s16_result), -260096);
`endif
      end
    end
    chk("s16_reads", rd_cnt, 16);
    chk("s16_idle", s16_busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
